// File: rtl/pe_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ PEs.
// Define PE_ARB_STATS_EN for per-PE saturating grant counters.
module pe_dmem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_we,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
`ifdef PE_ARB_STATS_EN
  input  logic                      stats_clr,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
  output logic                      busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CW-1:0]       r_cnt;

  logic                w_found;
  logic [PW-1:0]       w_win;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [NUM_REQ-1:0]  w_rsp_oh;

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = r_ptr;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_win   = PW'(j);
        w_we    = req_we[j];
        w_addr  = req_addr[j*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    w_rsp_oh = '0;
    if (r_state == S_IDLE && w_found)
      w_gnt_oh[w_win] = 1'b1;
    if (r_state == S_RESP)
      w_rsp_oh[r_win] = 1'b1;
  end

  assign req_ready = w_gnt_oh;
  assign rsp_valid = w_rsp_oh;
  assign rsp_rdata = r_rdata;
  assign busy      = (r_state != S_IDLE);

  // Decoded from state so reset clears the strobes without a clock.
  assign mem_we    = (r_state == S_ISSUE) & r_we;
  assign mem_rd_en = (r_state == S_ISSUE) & ~r_we;
  assign mem_addr  = (r_state == S_ISSUE) ? r_addr : '0;
  assign mem_wdata = mem_we ? r_wdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_win   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_win;
            r_ptr   <= w_win;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_state <= S_RESP;
          end else begin
            r_cnt   <= CW'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_rdata <= mem_rdata;
            r_state <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PE_ARB_STATS_EN
  logic [15:0] r_gcnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        r_gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          r_gcnt[i] <= '0;
        else if (w_gnt_oh[i] && r_gcnt[i] != 16'hFFFF)
          r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = r_gcnt[g];
  end
`endif

endmodule
